// File: rtl/neander_mem_arbiter_pkg.sv
// Shared types and helpers for the Neander-X RAM arbiter (CPU vs host loader port).
package neander_arb_pkg;

  localparam int STAT_W  = 16;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HOST_OWN = 2'd1,
    CPU_SLOT = 2'd2
  } arb_state_t;

  // True on the last host transfer a burst may take before the CPU gets a slot.
  function automatic logic burst_at_limit(input logic [BURST_W-1:0] cnt,
                                          input logic [BURST_W-1:0] lim);
    return cnt == (lim - 4'd1);
  endfunction

endpackage

// File: rtl/neander_mem_arbiter_if.sv
// CPU, host and RAM-side bus signals of the arbiter; slave = arbiter view, master = environment.
interface neander_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata, host_hold,
    output host_ack, host_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata, host_hold,
    input  host_ack, host_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/neander_mem_arbiter_stats.sv
// Host transfer counter (wrapping) and CPU stall-cycle counter (saturating).
module neander_arb_stats
  import neander_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer_i,
  input  logic              stall_i,
  output logic [STAT_W-1:0] stat_host_xfers_o,
  output logic [STAT_W-1:0] stat_stall_cycles_o
);

  logic [STAT_W-1:0] xfers_q, xfers_d;
  logic [STAT_W-1:0] stalls_q, stalls_d;

  always_comb begin
    xfers_d  = xfers_q;
    stalls_d = stalls_q;
    if (xfer_i) begin
      xfers_d = xfers_q + 16'd1;
    end else begin
      xfers_d = xfers_q;
    end
    if (stall_i && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end else begin
      stalls_d = stalls_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfers_q  <= 16'd0;
      stalls_q <= 16'd0;
    end else begin
      xfers_q  <= xfers_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_host_xfers_o   = xfers_q;
  assign stat_stall_cycles_o = stalls_q;

endmodule

// File: rtl/neander_mem_arbiter.sv
// RAM arbiter between the Neander-X CPU and the host loader port with bounded host bursts.
// Optional statistics counters are built only when MEM_ARB_STATS_EN is defined.
module neander_mem_arbiter
  import neander_arb_pkg::*;
#(
  parameter int HOST_BURST_MAX = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  neander_mem_arbiter_if.slave bus,
  output logic [STAT_W-1:0]    stat_host_xfers,
  output logic [STAT_W-1:0]    stat_stall_cycles
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(HOST_BURST_MAX);

  arb_state_t         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               host_sel_s;
  logic               xfer_s;
  logic [ADDR_W-1:0]  addr_mux_s;
  logic [DATA_W-1:0]  wdata_mux_s;

  assign host_sel_s  = (state_q == HOST_OWN);
  assign addr_mux_s  = host_sel_s ? bus.host_addr  : bus.cpu_addr;
  assign wdata_mux_s = host_sel_s ? bus.host_wdata : bus.cpu_wdata;

  // Reset gating keeps a write or grant from escaping while reset is asserted.
  assign bus.host_ack   = ~reset & host_sel_s;
  assign bus.ram_we     = ~reset & (host_sel_s ? (bus.host_req & bus.host_we) : bus.cpu_we);
  assign bus.ram_addr   = addr_mux_s;
  assign bus.ram_wdata  = wdata_mux_s;
  assign bus.cpu_stall  = host_sel_s;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.host_rdata = bus.ram_rdata;
  assign xfer_s         = bus.host_req & bus.host_ack;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      CPU_OWN: begin
        burst_d = 4'd0;
        if (bus.host_req || bus.host_hold) begin
          state_d = HOST_OWN;
        end else begin
          state_d = CPU_OWN;
        end
      end
      HOST_OWN: begin
        // Hold pins ownership and keeps the burst count from ever forcing a slot.
        if (bus.host_hold) begin
          burst_d = 4'd0;
        end else if (!bus.host_req) begin
          state_d = CPU_OWN;
          burst_d = 4'd0;
        end else if (xfer_s && burst_at_limit(burst_q, BURST_LIM)) begin
          state_d = CPU_SLOT;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      CPU_SLOT: begin
        burst_d = 4'd0;
        if (bus.host_req || bus.host_hold) begin
          state_d = HOST_OWN;
        end else begin
          state_d = CPU_OWN;
        end
      end
      default: begin
        state_d = CPU_OWN;
        burst_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  neander_arb_stats u_stats (
    .clk                 (clk),
    .reset               (reset),
    .xfer_i              (xfer_s),
    .stall_i             (bus.cpu_stall),
    .stat_host_xfers_o   (stat_host_xfers),
    .stat_stall_cycles_o (stat_stall_cycles)
  );
`else
  assign stat_host_xfers   = 16'd0;
  assign stat_stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Directed test of neander_mem_arbiter against a behavioural 256x8 RAM.
module tb_neander_mem_arbiter;
  import neander_arb_pkg::*;

  logic clk;
  logic reset;
  logic [STAT_W-1:0] stat_host_xfers;
  logic [STAT_W-1:0] stat_stall_cycles;
  logic [7:0] mem [256];
  int n_assert;
  int n_fail;

  neander_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  neander_mem_arbiter #(.HOST_BURST_MAX(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .stat_host_xfers   (stat_host_xfers),
    .stat_stall_cycles (stat_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] ack_exp;
    logic [7:0] k;
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset          = 1'b1;
    bus.cpu_addr   = 8'h00;
    bus.cpu_wdata  = 8'h00;
    bus.cpu_we     = 1'b1;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;
    bus.host_hold  = 1'b0;

    // Reset with host_req and cpu_we high
    #3;
    chk("rst_ram_we", 16'(bus.ram_we), 16'd0);
    chk("rst_ack", 16'(bus.host_ack), 16'd0);
    chk("rst_stall", 16'(bus.cpu_stall), 16'd0);
    tick(); tick();
    reset = 1'b0;
    bus.cpu_we = 1'b0;
    #2;
    chk("rel_ack0", 16'(bus.host_ack), 16'd0);
    tick();
    #2;
    chk("rel_ack1", 16'(bus.host_ack), 16'd1);
    bus.host_req = 1'b0;
    tick();

    // CPU write with host idle
    bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5; bus.cpu_we = 1'b1;
    #2;
    chk("cpu_wr_we", 16'(bus.ram_we), 16'd1);
    chk("cpu_wr_stall", 16'(bus.cpu_stall), 16'd0);
    tick();
    bus.cpu_we = 1'b0;
    #2;
    chk("cpu_wr_mem", 16'(mem[8'h10]), 16'h00A5);
    chk("cpu_wr_stall2", 16'(bus.cpu_stall), 16'd0);

    // Fresh reset so the stats reflect only the burst
    reset = 1'b1; #2; reset = 1'b0;
    tick();

    // Burst of 8 host writes, limit 4
    ack_exp = 10'b1111011110;
    k = 8'd0;
    bus.host_req = 1'b1; bus.host_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.host_addr  = 8'h20 + k;
      bus.host_wdata = k;
      #2;
      chk($sformatf("burst_ack%0d", i), 16'(bus.host_ack), 16'(ack_exp[i]));
      chk($sformatf("burst_stall%0d", i), 16'(bus.cpu_stall), 16'(ack_exp[i]));
      if (bus.host_ack) k = k + 8'd1;
      tick();
    end
    bus.host_req = 1'b0;
    #2;
    chk("burst_slot_stall", 16'(bus.cpu_stall), 16'd0);
    tick();
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("burst_mem%0d", j), 16'(mem[8'h20 + 8'(j)]), 16'(j));
    end
`ifdef MEM_ARB_STATS_EN
    chk("stat_xfers", stat_host_xfers, 16'd8);
    chk("stat_stalls", stat_stall_cycles, 16'd8);
`else
    chk("stat_xfers", stat_host_xfers, 16'd0);
    chk("stat_stalls", stat_stall_cycles, 16'd0);
`endif

    // Hold: first cycle still CPU's, then 12 host writes with no CPU slot
    bus.host_hold = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b1;
    bus.host_addr = 8'h40; bus.host_wdata = 8'h80;
    bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'h33; bus.cpu_we = 1'b1;
    #2;
    chk("hold_first_stall", 16'(bus.cpu_stall), 16'd0);
    chk("hold_first_we", 16'(bus.ram_we), 16'd1);
    tick();
    bus.cpu_wdata = 8'hEE;
    for (int i = 0; i < 12; i++) begin
      bus.host_addr  = 8'h40 + 8'(i);
      bus.host_wdata = 8'h80 + 8'(i);
      #2;
      chk($sformatf("hold_ack%0d", i), 16'(bus.host_ack), 16'd1);
      chk($sformatf("hold_stall%0d", i), 16'(bus.cpu_stall), 16'd1);
      tick();
    end
    bus.host_hold = 1'b0; bus.host_req = 1'b0; bus.cpu_we = 1'b0;
    tick();
    #2;
    chk("hold_cpu_mem", 16'(mem[8'h50]), 16'h0033);
    chk("hold_mem0", 16'(mem[8'h40]), 16'h0080);
    chk("hold_mem11", 16'(mem[8'h4B]), 16'h008B);
    chk("hold_end_stall", 16'(bus.cpu_stall), 16'd0);

    // Same-cycle host_req rise and CPU write, then host reads
    bus.cpu_addr = 8'h60; bus.cpu_wdata = 8'h5A; bus.cpu_we = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h60;
    #2;
    chk("same_ram_we", 16'(bus.ram_we), 16'd1);
    chk("same_ack0", 16'(bus.host_ack), 16'd0);
    tick();
    bus.cpu_we = 1'b0;
    #2;
    chk("same_ack1", 16'(bus.host_ack), 16'd1);
    chk("same_rdata", 16'(bus.host_rdata), 16'h005A);
    tick();
    bus.host_addr = 8'h10;
    #2;
    chk("rd_a5", 16'(bus.host_rdata), 16'h00A5);
    bus.host_req = 1'b0;
    tick();

    // Reset in the middle of a host write burst
    bus.host_req = 1'b1; bus.host_we = 1'b1;
    bus.host_addr = 8'h70; bus.host_wdata = 8'h11;
    tick();
    #2;
    chk("mid_ack_pre", 16'(bus.host_ack), 16'd1);
    tick();
    bus.host_addr = 8'h71; bus.host_wdata = 8'h22;
    reset = 1'b1;
    #2;
    chk("mid_rst_we", 16'(bus.ram_we), 16'd0);
    chk("mid_rst_ack", 16'(bus.host_ack), 16'd0);
    tick();
    reset = 1'b0; bus.host_req = 1'b0;
    tick();
    chk("mid_mem70", 16'(mem[8'h70]), 16'h0011);
    chk("mid_mem71", 16'(mem[8'h71]), 16'h0000);
    chk("mid_stall", 16'(bus.cpu_stall), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
